// File: rtl/cv32e40s_div_ctrl.sv
// cv32e40s_div_ctrl: issue-side controller for the EX-stage serial divider.
// Captures one DIV/DIVU/REM/REMU op, drives the divider, returns the result.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ex_*                  op request from EX (valid/ready, operator, operands)
//   halt_i, kill_i        freeze / abort from the controller
//   div_*_o               operator, operands and handshakes toward the divider
//   div_*_i               divider handshakes and result
//   wb_*                  result toward writeback (valid/ready)
//
// Operator encoding: 0=DIV 1=DIVU 2=REM 3=REMU.
// Build option: CV32E40S_DIV_CTRL_RESULT_BUF_EN adds a one-entry result
// buffer and a RESULT state, so the divider is released as soon as it
// finishes. Undefined, the result is passed straight through.

module cv32e40s_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [1:0]  ex_operator_i,
  input  logic [31:0] ex_op_a_i,
  input  logic [31:0] ex_op_b_i,
  input  logic        ex_data_ind_timing_i,
  input  logic        halt_i,
  input  logic        kill_i,
  output logic        div_valid_o,
  output logic [1:0]  div_operator_o,
  output logic [31:0] div_op_a_o,
  output logic [31:0] div_op_b_o,
  output logic        div_data_ind_timing_o,
  output logic        div_halt_o,
  output logic        div_kill_o,
  input  logic        div_ready_i,
  input  logic        div_valid_i,
  output logic        div_ready_o,
  input  logic [31:0] div_result_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [31:0] wb_result_o
);

`ifdef CV32E40S_DIV_CTRL_RESULT_BUF_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RESULT = 2'd2
  } state_e;
`else
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;
`endif

  state_e      state_q;
  state_e      state_d;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        dit_q;
  logic        accept;
  logic        xfer;
  logic        unused_div_ready;

  // The divider's input-side ready is not needed: the operands are held
  // in this block's register for the whole operation.
  assign unused_div_ready = div_ready_i;

  assign accept = ex_valid_i & ex_ready_o;
  assign xfer   = div_valid_i & div_ready_o;

  assign div_operator_o        = op_q;
  assign div_op_a_o            = a_q;
  assign div_op_b_o            = b_q;
  assign div_data_ind_timing_o = dit_q;
  assign div_halt_o            = halt_i;
  assign div_kill_o            = kill_i;

`ifdef CV32E40S_DIV_CTRL_RESULT_BUF_EN
  logic [31:0] res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else if (xfer && !kill_i) begin
      res_q <= div_result_i;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= ex_operator_i;
        a_q   <= ex_op_a_i;
        b_q   <= ex_op_b_i;
        dit_q <= ex_data_ind_timing_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ex_ready_o  = 1'b0;
    div_valid_o = 1'b0;
    div_ready_o = 1'b0;
    wb_valid_o  = 1'b0;
    wb_result_o = '0;
    unique case (state_q)
      IDLE: begin
        ex_ready_o = !halt_i && !kill_i;
        if (ex_valid_i && !halt_i && !kill_i) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Valid stays up across halt; only kill drops it.
        div_valid_o = !kill_i;
`ifdef CV32E40S_DIV_CTRL_RESULT_BUF_EN
        div_ready_o = !halt_i;
        if (div_valid_i && !halt_i) begin
          state_d = RESULT;
        end
`else
        div_ready_o = wb_ready_i && !halt_i;
        wb_valid_o  = div_valid_i && !halt_i && !kill_i;
        wb_result_o = div_result_i;
        ex_ready_o  = div_valid_i && wb_ready_i &&
                      !halt_i && !kill_i;
        if (div_valid_i && wb_ready_i && !halt_i) begin
          state_d = (ex_valid_i && !kill_i) ? BUSY : IDLE;
        end
`endif
      end
`ifdef CV32E40S_DIV_CTRL_RESULT_BUF_EN
      RESULT: begin
        wb_valid_o  = !halt_i && !kill_i;
        wb_result_o = res_q;
        ex_ready_o  = wb_ready_i && !halt_i && !kill_i;
        if (wb_ready_i && !halt_i) begin
          state_d = (ex_valid_i && !kill_i) ? BUSY : IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    // Kill overrides halt and every handshake.
    if (kill_i) begin
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_cv32e40s_div_ctrl.sv
// Bench for cv32e40s_div_ctrl: divider stub, transaction-level model,
// per-cycle compare process and directed scenarios.

module tb_cv32e40s_div_ctrl;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [1:0]  ex_operator_i;
  logic [31:0] ex_op_a_i;
  logic [31:0] ex_op_b_i;
  logic        ex_data_ind_timing_i;
  logic        halt_i;
  logic        kill_i;
  logic        div_valid_o;
  logic [1:0]  div_operator_o;
  logic [31:0] div_op_a_o;
  logic [31:0] div_op_b_o;
  logic        div_data_ind_timing_o;
  logic        div_halt_o;
  logic        div_kill_o;
  logic        div_ready_i;
  logic        div_valid_i;
  logic        div_ready_o;
  logic [31:0] div_result_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_result_o;

  int err = 0;
  int cnt = 0;
  int wb_cnt = 0;

  always #5 clk = ~clk;

  cv32e40s_div_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .ex_valid_i            (ex_valid_i),
    .ex_ready_o            (ex_ready_o),
    .ex_operator_i         (ex_operator_i),
    .ex_op_a_i             (ex_op_a_i),
    .ex_op_b_i             (ex_op_b_i),
    .ex_data_ind_timing_i  (ex_data_ind_timing_i),
    .halt_i                (halt_i),
    .kill_i                (kill_i),
    .div_valid_o           (div_valid_o),
    .div_operator_o        (div_operator_o),
    .div_op_a_o            (div_op_a_o),
    .div_op_b_o            (div_op_b_o),
    .div_data_ind_timing_o (div_data_ind_timing_o),
    .div_halt_o            (div_halt_o),
    .div_kill_o            (div_kill_o),
    .div_ready_i           (div_ready_i),
    .div_valid_i           (div_valid_i),
    .div_ready_o           (div_ready_o),
    .div_result_i          (div_result_i),
    .wb_valid_o            (wb_valid_o),
    .wb_ready_i            (wb_ready_i),
    .wb_result_o           (wb_result_o)
  );

  // RISC-V M-extension divide semantics.
  function automatic logic [31:0] golden(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    cnt++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s t=%0t actual=%h expected=%h",
               name, $time, act, exp);
    end
  endtask

  // Divider stub: LAT un-halted cycles of div_valid_o, then holds its
  // result valid until taken or killed.
  int   dcnt;
  logic ddone;

  always @(posedge clk) begin
    if (rst || div_kill_o) begin
      dcnt  <= 0;
      ddone <= 1'b0;
    end else if (ddone) begin
      if (div_ready_o) ddone <= 1'b0;
    end else if (div_valid_o && !div_halt_o) begin
      if (dcnt == LAT - 1) begin
        ddone <= 1'b1;
        dcnt  <= 0;
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  assign div_ready_i  = 1'b1;
  assign div_valid_i  = ddone;
  assign div_result_i = ddone ?
    golden(div_operator_o, div_op_a_o, div_op_b_o) : 32'h0;

  // Model: which op is outstanding, and whether it sits at the divider
  // or (with the buffer) as a held result.
  logic        m_at;
  logic        m_held;
  logic [1:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_dit;
  logic [31:0] m_hv;

  always @(negedge clk) begin : cmp
    logic e_dv;
    logic e_dr;
    logic e_wv;
    logic e_er;
    logic xfer;
    logic acc;
    if (rst) begin
      m_at   <= 1'b0;
      m_held <= 1'b0;
      m_op   <= '0;
      m_a    <= '0;
      m_b    <= '0;
      m_dit  <= 1'b0;
      m_hv   <= '0;
    end else begin
      chk("div_halt", 32'(div_halt_o), 32'(halt_i));
      chk("div_kill", 32'(div_kill_o), 32'(kill_i));
      chk("div_op", 32'(div_operator_o), 32'(m_op));
      chk("div_a", div_op_a_o, m_a);
      chk("div_b", div_op_b_o, m_b);
      chk("div_dit", 32'(div_data_ind_timing_o), 32'(m_dit));
`ifdef CV32E40S_DIV_CTRL_RESULT_BUF_EN
      e_dv = m_at && !kill_i;
      e_dr = m_at && !halt_i;
      e_wv = m_held && !halt_i && !kill_i;
      e_er = !kill_i && !halt_i &&
             ((!m_at && !m_held) || (m_held && wb_ready_i));
`else
      e_dv = m_at && !kill_i;
      e_dr = m_at && wb_ready_i && !halt_i;
      e_wv = m_at && div_valid_i && !halt_i && !kill_i;
      e_er = !kill_i && !halt_i &&
             (!m_at || (div_valid_i && wb_ready_i));
`endif
      chk("div_valid", 32'(div_valid_o), 32'(e_dv));
      chk("div_ready", 32'(div_ready_o), 32'(e_dr));
      chk("wb_valid", 32'(wb_valid_o), 32'(e_wv));
      chk("ex_ready", 32'(ex_ready_o), 32'(e_er));
      if (e_wv) begin
`ifdef CV32E40S_DIV_CTRL_RESULT_BUF_EN
        chk("wb_result", wb_result_o, m_hv);
`else
        chk("wb_result", wb_result_o, golden(m_op, m_a, m_b));
`endif
      end
      if (wb_valid_o && wb_ready_i) wb_cnt <= wb_cnt + 1;
      xfer = m_at && div_valid_i && e_dr;
      acc  = ex_valid_i && e_er;
      if (kill_i) begin
        m_at   <= 1'b0;
        m_held <= 1'b0;
      end else if (!halt_i) begin
`ifdef CV32E40S_DIV_CTRL_RESULT_BUF_EN
        if (xfer) begin
          m_at   <= 1'b0;
          m_held <= 1'b1;
          m_hv   <= golden(m_op, m_a, m_b);
        end else if (m_held && wb_ready_i) begin
          m_held <= 1'b0;
        end
`else
        if (xfer) m_at <= 1'b0;
`endif
        if (acc) begin
          m_at  <= 1'b1;
          m_op  <= ex_operator_i;
          m_a   <= ex_op_a_i;
          m_b   <= ex_op_b_i;
          m_dit <= ex_data_ind_timing_i;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic dit);
    logic ok;
    ok = 1'b0;
    ex_valid_i           = 1'b1;
    ex_operator_i        = op;
    ex_op_a_i            = a;
    ex_op_b_i            = b;
    ex_data_ind_timing_i = dit;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ex_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 32'(ok), 32'd1);
    step();
    ex_valid_i = 1'b0;
  endtask

  task automatic wait_wb(input string name, input logic [31:0] exp);
    logic        ok;
    logic [31:0] res;
    ok  = 1'b0;
    res = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wb_valid_o && wb_ready_i) begin
        ok  = 1'b1;
        res = wb_result_o;
        break;
      end
    end
    if (!ok) chk({name, "_timeout"}, 32'(ok), 32'd1);
    else chk(name, res, exp);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running expected=done", $time);
    $fatal(1);
  end

  initial begin
    int c0;
    logic found;
    rst                  = 1'b1;
    ex_valid_i           = 1'b0;
    ex_operator_i        = '0;
    ex_op_a_i            = '0;
    ex_op_b_i            = '0;
    ex_data_ind_timing_i = 1'b0;
    halt_i               = 1'b0;
    kill_i               = 1'b0;
    wb_ready_i           = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready_o), 32'd1);
    chk("rst_div_valid", 32'(div_valid_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_div_ready", 32'(div_ready_o), 32'd0);
    chk("rst_div_kill", 32'(div_kill_o), 32'd0);
    chk("rst_div_halt", 32'(div_halt_o), 32'd0);
    chk("rst_op_a", div_op_a_o, 32'd0);
    chk("rst_wb_result", wb_result_o, 32'd0);
    step();

    // Basic DIV, single result pulse
    c0 = wb_cnt;
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    wait_wb("div_100_7", 32'd14);
    repeat (3) step();
    chk("div_pulses", 32'(wb_cnt - c0), 32'd1);

    issue(OP_REM, 32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_wb("rem_m100_7", 32'hFFFF_FFFE);
    issue(OP_DIVU, 32'd5, 32'd0, 1'b0);
    wait_wb("divu_5_0", 32'hFFFF_FFFF);
    issue(OP_REMU, 32'd17, 32'd5, 1'b0);
    wait_wb("remu_17_5", 32'd2);

    // Kill mid-operation
    c0 = wb_cnt;
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (2) step();
    kill_i = 1'b1;
    @(negedge clk);
    chk("kill_out", 32'(div_kill_o), 32'd1);
    chk("kill_div_valid", 32'(div_valid_o), 32'd0);
    step();
    kill_i = 1'b0;
    @(negedge clk);
    chk("kill_idle_ready", 32'(ex_ready_o), 32'd1);
    chk("kill_kill_low", 32'(div_kill_o), 32'd0);
    repeat (10) step();
    chk("kill_pulses", 32'(wb_cnt - c0), 32'd0);
    issue(OP_DIVU, 32'd9, 32'd3, 1'b0);
    wait_wb("divu_9_3", 32'd3);

    // Halt for 10 cycles mid-BUSY
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    step();
    halt_i = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("halt_a", div_op_a_o, 32'd100);
      chk("halt_b", div_op_b_o, 32'd7);
      chk("halt_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("halt_ex_ready", 32'(ex_ready_o), 32'd0);
      chk("halt_div_valid", 32'(div_valid_o), 32'd1);
    end
    step();
    halt_i = 1'b0;
    wait_wb("halt_div", 32'd14);

    // Writeback stall at completion, back-to-back on release
    wb_ready_i = 1'b0;
    issue(OP_DIVU, 32'd200, 32'd10, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wb_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_seen", 32'(found), 32'd1);
    repeat (5) begin
      chk("stall_wb_valid", 32'(wb_valid_o), 32'd1);
      chk("stall_result", wb_result_o, 32'd20);
`ifndef CV32E40S_DIV_CTRL_RESULT_BUF_EN
      chk("stall_div_ready", 32'(div_ready_o), 32'd0);
      chk("stall_div_vld_in", 32'(div_valid_i), 32'd1);
`endif
      @(negedge clk);
    end
    step();
    wb_ready_i    = 1'b1;
    ex_valid_i    = 1'b1;
    ex_operator_i = OP_DIVU;
    ex_op_a_i     = 32'd9;
    ex_op_b_i     = 32'd3;
    @(negedge clk);
    chk("rel_wb_valid", 32'(wb_valid_o), 32'd1);
    chk("rel_result", wb_result_o, 32'd20);
    chk("rel_ex_ready", 32'(ex_ready_o), 32'd1);
    step();
    ex_valid_i = 1'b0;
    wait_wb("b2b_divu_9_3", 32'd3);

    // Kill on the divider transfer cycle
    c0 = wb_cnt;
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (LAT) step();
    kill_i = 1'b1;
    @(negedge clk);
    chk("kx_div_valid_in", 32'(div_valid_i), 32'd1);
    chk("kx_wb_valid", 32'(wb_valid_o), 32'd0);
    step();
    kill_i = 1'b0;
    repeat (10) step();
    chk("kx_pulses", 32'(wb_cnt - c0), 32'd0);

    // Reset while BUSY
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rb_div_valid", 32'(div_valid_o), 32'd0);
    chk("rb_ex_ready", 32'(ex_ready_o), 32'd1);
    chk("rb_op_a", div_op_a_o, 32'd0);
    step();
    issue(OP_REM, 32'd100, 32'd7, 1'b0);
    wait_wb("rem_100_7", 32'd2);

    $display("Result: errors=%0d of %0d checks", err, cnt);
    $finish;
  end

endmodule
